mem_ctrl_param: RTL
===================

# mem_ctrl_param

Parametrised single-port synchronous memory with a valid/ready request interface, per-byte write enables and a registered read response. After every reset it runs a hardware clear sweep that writes INIT_VAL to each word. It is the next generation of the team's fixed 8x8 memory and serves as a generic scratch/buffer RAM behind any requester that speaks valid/ready.

## Interface
Parameters:
- DATA_W, default 8: word width; must be a multiple of 8.
- ADDR_W, default 3: address width.
- DEPTH, default 8: number of words; 1 <= DEPTH <= 2^ADDR_W.
- INIT_VAL, default 0: value written to every word by the clear sweep.
- BE_W: derived as DATA_W/8; not overridable.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block accepts a request this cycle.
- req_op  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- req_be  in  BE_W  byte enables; bit i enables bits [8i+7:8i].
- rsp_valid  out  1  read response valid, one-cycle pulse per read.
- rsp_data  out  DATA_W  read data.
- rsp_err  out  1  address out of range; qualified by rsp_valid.
- init_done  out  1  clear sweep complete.

## Operation
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, init_done=0. The clear counter is 0 and the FSM is in CLEAR.
- FSM states: CLEAR and RUN.
- CLEAR:
  - Each cycle, write INIT_VAL to word clr_cnt and increment clr_cnt. clr_cnt is ADDR_W+1 bits wide.
  - Leave for RUN after the write to word DEPTH-1.
  - req_ready=0. Any request is ignored, not queued.
- RUN:
  - req_ready=1 and init_done=1 continuously.
  - A handshake is req_valid & req_ready.
- Write handshake:
  - For each set bit in req_be, update that byte lane of mem[req_addr]. Clear lanes keep their value.
  - req_be=0 is a legal no-op.
  - A write produces no response.
- Read handshake:
  - Returns mem[req_addr] on rsp_data with rsp_valid=1 and rsp_err=0.
  - req_be is ignored.
- Out-of-range address (req_addr >= DEPTH):
  - A write is dropped.
  - A read returns rsp_data=0 with rsp_err=1 and rsp_valid=1.
- Ordering:
  - A read accepted the cycle after a write to the same address returns the new data.
  - Only one operation is possible per cycle, so there is no same-cycle conflict.
- rsp_data holds its last value while rsp_valid=0. rsp_err is cleared when rsp_valid=0.
- Reset asserted at any time, including mid-sweep or with a response in flight:
  - The next cycle shows the reset values and any pending response is discarded.
  - The sweep restarts from word 0.
  - Memory contents are indeterminate until init_done=1.

## Timing
- Clear sweep: for DEPTH cycles after the cycle in which reset is sampled low, no requests are accepted.
- init_done and req_ready rise together on the following edge.
- Read latency: rsp_valid is asserted on the edge after acceptance (1 cycle) without PMEM_OUTREG_EN, or 2 cycles with it.
- Throughput: one request per cycle sustained. Back-to-back reads give back-to-back rsp_valid pulses in request order.
- No backpressure on the response: the consumer must take rsp_data in the cycle rsp_valid=1.
- Write visibility: data written at edge N is readable by a request accepted at edge N+1.

## Configuration
- PMEM_OUTREG_EN defined:
  - Adds a second pipeline register on rsp_valid, rsp_data and rsp_err, giving read latency 2.
  - Throughput is unchanged.
  - The extra register stage resets to 0 and is flushed by reset.
- PMEM_OUTREG_EN undefined: single response register, read latency 1.

## Test plan
- Reset held for 2 cycles, then released:
  - req_ready=0 for exactly 8 cycles (defaults), then req_ready=1 and init_done=1.
  - Reads of addresses 0..7 all return 0x00 with rsp_err=0.
- Write 0xA5 to addr 3 with req_be=1, then read addr 3 on the next cycle:
  - rsp_data=0xA5, with rsp_valid after 1 cycle (2 with PMEM_OUTREG_EN).
- DATA_W=32: write 0x11223344 with be=4'hF, then 0xAABBCCDD with be=4'b0101, then read:
  - Returns 0x11BB33DD.
- DEPTH=6, ADDR_W=3: write 0x55 to addr 7, then read addr 7:
  - rsp_valid=1, rsp_err=1, rsp_data=0.
  - A read of addr 5 returns INIT_VAL.
- Back-to-back reads of addrs 0,1,2 preloaded with 0x10,0x20,0x30:
  - rsp_valid high for 3 consecutive cycles with data 0x10, 0x20, 0x30 in order.
- Reset asserted during sweep cycle 4, and separately one cycle after a read is accepted:
  - Next cycle rsp_valid=0 and req_ready=0.
  - The sweep restarts and lasts the full DEPTH cycles.
  - No response for the discarded read ever appears.

Source files
------------

// File: rtl/mem_ctrl_param.sv
// Parametrised single-port RAM with a valid/ready request port, byte enables and a
// hardware clear sweep after reset. Define PMEM_OUTREG_EN to add a second response stage.
module mem_ctrl_param #(
    parameter int                 DATA_W   = 8,
    parameter int                 ADDR_W   = 3,
    parameter int                 DEPTH    = 8,
    parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_op,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_data,
    output logic                  rsp_err,
    output logic                  init_done
);

    localparam int                BE_W    = DATA_W / 8;
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   LAST_C  = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0]   ONE_C   = (ADDR_W + 1)'(1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic [ADDR_W:0]      clr_cnt_r;
    logic [ADDR_W:0]      clr_cnt_s;
    logic                 ready_r;
    logic                 init_done_r;

    logic [DATA_W-1:0]    mem_r [DEPTH];
    logic                 mem_we_s;
    logic [ADDR_W-1:0]    mem_waddr_s;
    logic [DATA_W-1:0]    mem_wdata_s;

    logic                 hs_s;
    logic                 wr_hs_s;
    logic                 rd_hs_s;
    logic                 in_range_s;
    logic [DATA_W-1:0]    rd_data_s;

    logic                 rsp_valid1_r;
    logic [DATA_W-1:0]    rsp_data1_r;
    logic                 rsp_err1_r;

    // Replace only the byte lanes whose enable bit is set.
    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return res;
    endfunction

    assign hs_s       = req_valid & ready_r;
    assign wr_hs_s    = hs_s & req_op;
    assign rd_hs_s    = hs_s & ~req_op;
    assign in_range_s = ({1'b0, req_addr} < DEPTH_C);

    // Read data mux; out-of-range reads return zero.
    always_comb begin
        rd_data_s = '0;
        if (in_range_s) begin
            rd_data_s = mem_r[req_addr];
        end else begin
            rd_data_s = '0;
        end
    end

    // Next-state logic and the single memory write port (sweep or request).
    always_comb begin
        state_s     = state_r;
        clr_cnt_s   = clr_cnt_r;
        mem_we_s    = 1'b0;
        mem_waddr_s = '0;
        mem_wdata_s = '0;
        case (state_r)
            ST_CLEAR: begin
                mem_we_s    = 1'b1;
                mem_waddr_s = clr_cnt_r[ADDR_W-1:0];
                mem_wdata_s = INIT_VAL;
                clr_cnt_s   = clr_cnt_r + ONE_C;
                if (clr_cnt_r == LAST_C) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_CLEAR;
                end
            end
            ST_RUN: begin
                state_s = ST_RUN;
                if (wr_hs_s && in_range_s) begin
                    mem_we_s    = 1'b1;
                    mem_waddr_s = req_addr;
                    mem_wdata_s = merge_bytes(mem_r[req_addr], req_wdata, req_be);
                end else begin
                    mem_we_s    = 1'b0;
                end
            end
            default: begin
                state_s = ST_CLEAR;
            end
        endcase
    end

    // Control registers; ready and init_done follow the state the FSM is entering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_CLEAR;
            clr_cnt_r   <= '0;
            ready_r     <= 1'b0;
            init_done_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            clr_cnt_r   <= clr_cnt_s;
            ready_r     <= (state_s == ST_RUN);
            init_done_r <= (state_s == ST_RUN);
        end
    end

    // Storage array; contents are not reset, the sweep initialises them.
    always_ff @(posedge clk) begin
        if (mem_we_s && !reset) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // First response stage; data holds between reads, err only lives with valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid1_r <= 1'b0;
            rsp_data1_r  <= '0;
            rsp_err1_r   <= 1'b0;
        end else begin
            rsp_valid1_r <= rd_hs_s;
            rsp_err1_r   <= rd_hs_s & ~in_range_s;
            if (rd_hs_s) begin
                rsp_data1_r <= rd_data_s;
            end
        end
    end

`ifdef PMEM_OUTREG_EN
    logic                 rsp_valid2_r;
    logic [DATA_W-1:0]    rsp_data2_r;
    logic                 rsp_err2_r;

    // Optional second response stage, flushed by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid2_r <= 1'b0;
            rsp_data2_r  <= '0;
            rsp_err2_r   <= 1'b0;
        end else begin
            rsp_valid2_r <= rsp_valid1_r;
            rsp_err2_r   <= rsp_err1_r;
            if (rsp_valid1_r) begin
                rsp_data2_r <= rsp_data1_r;
            end
        end
    end

    assign rsp_valid = rsp_valid2_r;
    assign rsp_data  = rsp_data2_r;
    assign rsp_err   = rsp_err2_r;
`else
    assign rsp_valid = rsp_valid1_r;
    assign rsp_data  = rsp_data1_r;
    assign rsp_err   = rsp_err1_r;
`endif

    assign req_ready = ready_r;
    assign init_done = init_done_r;

endmodule
